// File: rtl/pace_if.sv
// pace_if: bundle between the pace controller and the game peers (buttons, collision, obstacle controller).
// The pause signal exists only when PACE_PAUSE_EN is defined.
interface pace_if;
  logic        start;
  logic        collide;
  logic [15:0] score;
`ifdef PACE_PAUSE_EN
  logic        pause;
`endif
  logic        game_clk;
  logic        game_rst;
  logic        over;
  logic        running;
  logic [3:0]  level;
  logic [8:0]  minEmpty;

  // Plain level signals, no handshake: inputs are sampled every clk, outputs are registered.
`ifdef PACE_PAUSE_EN
  modport master (
    input  start, collide, score, pause,
    output game_clk, game_rst, over, running, level, minEmpty
  );
  modport slave (
    output start, collide, score, pause,
    input  game_clk, game_rst, over, running, level, minEmpty
  );
`else
  modport master (
    input  start, collide, score,
    output game_clk, game_rst, over, running, level, minEmpty
  );
  modport slave (
    output start, collide, score,
    input  game_clk, game_rst, over, running, level, minEmpty
  );
`endif
endinterface

// File: rtl/pace_ctrl.sv
// pace_ctrl: IDLE/CLEAR/RUN/OVER game-flow FSM plus a score-paced game_clk divider.
// Define PACE_PAUSE_EN to add the pause input and the PAUSE state.
module pace_ctrl #(
  parameter int unsigned HALF_BASE = 125000,
  parameter int unsigned HALF_STEP = 6250,
  parameter int unsigned MAX_LEVEL = 10,
  parameter int unsigned GAP_BASE  = 300,
  parameter int unsigned GAP_STEP  = 15,
  parameter int unsigned RST_HOLD  = 2
) (
  input  logic       clk,
  input  logic       rst,
  pace_if.master     pace_io,
  output logic [2:0] state_o
);

  localparam int DW = $clog2(HALF_BASE + 1);
  localparam int CW = $clog2(RST_HOLD + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_OVER  = 3'd3
`ifdef PACE_PAUSE_EN
    ,S_PAUSE = 3'd4
`endif
  } state_t;

  state_t          state_q;
  logic [DW-1:0]   div_q;
  logic            gclk_q;
  logic            grst_q;
  logic            over_q;
  logic            running_q;
  logic [3:0]      level_q;
  logic [8:0]      gap_q;
  logic            start_q;
  logic [CW-1:0]   edge_cnt_q;
`ifdef PACE_PAUSE_EN
  logic            pause_q;
  logic            pause_rise;
`endif

  logic            start_rise;
  logic            go_clear;
  logic [7:0]      hundreds;
  logic [3:0]      lvl_clamp;
  logic [3:0]      level_d;
  logic [8:0]      gap_d;
  logic [31:0]     half_prod;
  logic [31:0]     half_len;
  logic            tick;
  logic            rise_now;

  always_comb begin
    start_rise = pace_io.start & ~start_q;
`ifdef PACE_PAUSE_EN
    pause_rise = pace_io.pause & ~pause_q;
    go_clear   = start_rise & ((state_q == S_IDLE) | (state_q == S_OVER) | (state_q == S_PAUSE));
`else
    go_clear   = start_rise & ((state_q == S_IDLE) | (state_q == S_OVER));
`endif

    hundreds  = 8'(pace_io.score[15:12]) * 8'd10 + 8'(pace_io.score[11:8]);
    lvl_clamp = (hundreds > 8'(MAX_LEVEL)) ? 4'(MAX_LEVEL) : hundreds[3:0];
    // Level is monotonic within a game, so only ever take the larger value.
    level_d   = (lvl_clamp > level_q) ? lvl_clamp : level_q;
    gap_d     = 9'(GAP_BASE - 32'(level_d) * GAP_STEP);

    // A fully sped-up level may push the half-period to zero or below; floor it at one clk.
    half_prod = 32'(level_q) * HALF_STEP;
    half_len  = (HALF_BASE > half_prod) ? (HALF_BASE - half_prod) : 32'd1;
    tick      = (32'(div_q) >= (half_len - 32'd1));
    rise_now  = tick & ~gclk_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      gclk_q     <= 1'b0;
      grst_q     <= 1'b0;
      over_q     <= 1'b1;
      running_q  <= 1'b0;
      level_q    <= 4'd0;
      gap_q      <= 9'(GAP_BASE);
      start_q    <= 1'b1;
      edge_cnt_q <= '0;
`ifdef PACE_PAUSE_EN
      pause_q    <= 1'b1;
`endif
    end else begin
      start_q <= pace_io.start;
`ifdef PACE_PAUSE_EN
      pause_q <= pace_io.pause;
`endif

      if (tick) begin
        div_q  <= '0;
        gclk_q <= ~gclk_q;
      end else begin
        div_q  <= div_q + DW'(1);
      end

      if (go_clear) begin
        state_q    <= S_CLEAR;
        grst_q     <= 1'b1;
        over_q     <= 1'b0;
        running_q  <= 1'b0;
        level_q    <= 4'd0;
        gap_q      <= 9'(GAP_BASE);
        edge_cnt_q <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            over_q    <= 1'b1;
            running_q <= 1'b0;
          end
          S_CLEAR: begin
            // Release one clk after the last counted edge so game_rst is stable across it.
            if (edge_cnt_q == CW'(RST_HOLD)) begin
              grst_q    <= 1'b0;
              running_q <= 1'b1;
              state_q   <= S_RUN;
            end else if (rise_now) begin
              edge_cnt_q <= edge_cnt_q + CW'(1);
            end
          end
          S_RUN: begin
            level_q <= level_d;
            gap_q   <= gap_d;
            if (pace_io.collide) begin
              over_q    <= 1'b1;
              running_q <= 1'b0;
              state_q   <= S_OVER;
`ifdef PACE_PAUSE_EN
            end else if (pause_rise) begin
              over_q    <= 1'b1;
              running_q <= 1'b0;
              state_q   <= S_PAUSE;
`endif
            end
          end
          S_OVER: begin
            over_q    <= 1'b1;
            running_q <= 1'b0;
          end
`ifdef PACE_PAUSE_EN
          S_PAUSE: begin
            if (pause_rise) begin
              over_q    <= 1'b0;
              running_q <= 1'b1;
              state_q   <= S_RUN;
            end
          end
`endif
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign pace_io.game_clk = gclk_q;
  assign pace_io.game_rst = grst_q;
  assign pace_io.over     = over_q;
  assign pace_io.running  = running_q;
  assign pace_io.level    = level_q;
  assign pace_io.minEmpty = gap_q;
  assign state_o          = state_q;

endmodule

// File: tb/tb_pace_ctrl.sv
// tb_pace_ctrl: directed bench for pace_ctrl with a short divider (HALF_BASE=10, HALF_STEP=1).
// Define PACE_PAUSE_EN for both files to exercise the pause path.
module tb_pace_ctrl;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_OVER  = 3'd3;
  localparam logic [2:0] S_PAUSE = 3'd4;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] state;
  int         n_total = 0;
  int         n_bad   = 0;

  pace_if bus();

  pace_ctrl #(
    .HALF_BASE(10), .HALF_STEP(1), .MAX_LEVEL(10),
    .GAP_BASE(300), .GAP_STEP(15), .RST_HOLD(2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .pace_io (bus),
    .state_o (state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Clks until game_clk next changes, capped at 200.
  task automatic half_period(output int n);
    logic prev;
    prev = bus.game_clk;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.game_clk == prev && n < 200);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
  endtask

  initial begin
    int n;
    int rises;
    int entries;
    int flag;
    logic prev_g, prev_r;
    logic [2:0] prev_s;

    bus.start   = 1'b0;
    bus.collide = 1'b0;
    bus.score   = 16'h0000;
`ifdef PACE_PAUSE_EN
    bus.pause   = 1'b0;
`endif
    rst = 1'b1;
    step(3);

    // reset values
    check("rst_state",    32'(state),            32'(S_IDLE));
    check("rst_game_clk", 32'(bus.game_clk),     0);
    check("rst_game_rst", 32'(bus.game_rst),     0);
    check("rst_over",     32'(bus.over),         1);
    check("rst_running",  32'(bus.running),      0);
    check("rst_level",    32'(bus.level),        0);
    check("rst_minEmpty", 32'(bus.minEmpty),     300);

    // idle: divider free-runs at half=10, collide has no effect
    rst = 1'b0;
    half_period(n);
    half_period(n);
    check("idle_half", n, 10);
    bus.collide = 1'b1;
    flag = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (bus.over !== 1'b1 || bus.game_rst !== 1'b0 || state !== S_IDLE) flag = 1;
    end
    bus.collide = 1'b0;
    check("idle_hold",     flag, 0);
    check("idle_minEmpty", 32'(bus.minEmpty), 300);

    // start -> CLEAR, game_rst held over exactly two game_clk rising edges
    pulse_start();
    check("clr_state",    32'(state),        32'(S_CLEAR));
    check("clr_game_rst", 32'(bus.game_rst), 1);
    check("clr_over",     32'(bus.over),     0);
    prev_g = bus.game_clk;
    prev_r = bus.game_rst;
    rises = 0;
    n = 0;
    while (bus.game_rst && n < 200) begin
      step(1);
      n++;
      if (prev_r && !prev_g && bus.game_clk) rises++;
      prev_g = bus.game_clk;
      prev_r = bus.game_rst;
    end
    check("clr_rises",   rises, 2);
    check("run_state",   32'(state),       32'(S_RUN));
    check("run_running", 32'(bus.running), 1);
    check("run_over",    32'(bus.over),    0);

    // score-driven level, gap and pace
    bus.score = 16'h0345;
    step(1);
    check("lvl3_level",    32'(bus.level),    3);
    check("lvl3_minEmpty", 32'(bus.minEmpty), 255);
    half_period(n);
    half_period(n);
    check("lvl3_half", n, 7);
    bus.score = 16'h1500;
    step(1);
    check("lvl10_level",    32'(bus.level),    10);
    check("lvl10_minEmpty", 32'(bus.minEmpty), 150);
    half_period(n);
    half_period(n);
    check("lvl10_half", n, 1);
    bus.score = 16'h0345;
    step(2);
    check("lvl_no_drop", 32'(bus.level), 10);

    // collide beats a simultaneous start edge
    bus.collide = 1'b1;
    bus.start   = 1'b1;
    step(1);
    bus.start   = 1'b0;
    check("ovr_state",    32'(state),         32'(S_OVER));
    check("ovr_over",     32'(bus.over),      1);
    check("ovr_running",  32'(bus.running),   0);
    check("ovr_level",    32'(bus.level),     10);
    check("ovr_minEmpty", 32'(bus.minEmpty),  150);
    step(3);
    bus.collide = 1'b0;
    check("ovr_collide_ign", 32'(state), 32'(S_OVER));
    pulse_start();
    check("restart_state",    32'(state),        32'(S_CLEAR));
    check("restart_level",    32'(bus.level),    0);
    check("restart_minEmpty", 32'(bus.minEmpty), 300);
    check("restart_game_rst", 32'(bus.game_rst), 1);

    // mid-game reset with start held through deassert
    step(1);
    rst = 1'b1;
    bus.start = 1'b1;
    step(1);
    check("mrst_game_clk", 32'(bus.game_clk), 0);
    check("mrst_game_rst", 32'(bus.game_rst), 0);
    check("mrst_state",    32'(state),        32'(S_IDLE));
    check("mrst_over",     32'(bus.over),     1);
    step(2);
    rst = 1'b0;
    step(5);
    check("held_start_idle", 32'(state), 32'(S_IDLE));
    bus.start = 1'b0;
    step(2);
    bus.start = 1'b1;
    entries = 0;
    prev_s = state;
    for (int i = 0; i < 80; i++) begin
      step(1);
      if (state == S_CLEAR && prev_s != S_CLEAR) entries++;
      prev_s = state;
    end
    bus.start = 1'b0;
    check("one_clear_entry", entries, 1);
    check("held_start_run",  32'(state), 32'(S_RUN));

`ifdef PACE_PAUSE_EN
    // pause toggles RUN <-> PAUSE, collide ignored while paused
    step(2);
    bus.pause = 1'b1;
    step(1);
    bus.pause = 1'b0;
    check("pse_state",   32'(state),       32'(S_PAUSE));
    check("pse_over",    32'(bus.over),    1);
    check("pse_running", 32'(bus.running), 0);
    check("pse_level",   32'(bus.level),   3);
    bus.collide = 1'b1;
    step(3);
    bus.collide = 1'b0;
    check("pse_collide_ign", 32'(state), 32'(S_PAUSE));
    bus.pause = 1'b1;
    step(1);
    bus.pause = 1'b0;
    check("resume_state",   32'(state),       32'(S_RUN));
    check("resume_over",    32'(bus.over),    0);
    check("resume_running", 32'(bus.running), 1);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
